// File: rtl/color_vote_filter_if.sv
// ---------------------------------------------------------------------------
// color_vote_filter_if : sample/flag inputs, stable colour outputs and event
// handshake of color_vote_filter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface color_vote_filter_if;
  logic       sample_valid;
  logic       red_detected;
  logic       green_detected;
  logic       black_detected;
  logic [1:0] stable_color;
  logic       stable_valid;
  logic [3:0] confidence;
  logic       stale;
  logic       evt_valid;
  logic [1:0] evt_color;
  logic       evt_ready;
  logic       evt_overrun;

  modport master (
    output sample_valid, red_detected, green_detected, black_detected, evt_ready,
    input  stable_color, stable_valid, confidence, stale, evt_valid, evt_color, evt_overrun
  );

  modport slave (
    input  sample_valid, red_detected, green_detected, black_detected, evt_ready,
    output stable_color, stable_valid, confidence, stale, evt_valid, evt_color, evt_overrun
  );
endinterface

`default_nettype wire

// File: rtl/color_vote_filter.sv
// ---------------------------------------------------------------------------
// color_vote_filter : debounces per-frame colour flags into a confirmed colour
// with change events, mismatch hysteresis and a stale-input watchdog. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module color_vote_filter #(
  parameter int CONFIRM_FRAMES = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  color_vote_filter_if.slave  bus
);

  localparam logic [3:0]  CONFIRM      = 4'(CONFIRM_FRAMES);
  localparam logic [23:0] TIMEOUT_MAX  = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  cand, cand_next;
  logic [1:0]  stable, stable_next;
  logic [3:0]  count, count_next;
  logic [3:0]  count_inc;
  logic [1:0]  sample_class;
  logic        raise;
  logic [1:0]  raise_color;
  logic [23:0] wd;
  logic        timeout_hit;
  logic        stale_q;
  logic        evt_valid_q;
  logic [1:0]  evt_color_q;
  logic        overrun_q;

  always_comb begin
    sample_class = 2'b00;
    if (bus.black_detected)      sample_class = 2'b11;
    else if (bus.red_detected)   sample_class = 2'b01;
    else if (bus.green_detected) sample_class = 2'b10;
  end

  assign count_inc = count + 4'd1;
  // Fires once, on the cycle the watchdog would reach the limit; a sample wins.
  assign timeout_hit = !bus.sample_valid && (wd == TIMEOUT_LAST);

  always_comb begin
    state_next  = state;
    cand_next   = cand;
    stable_next = stable;
    count_next  = count;
    raise       = 1'b0;
    raise_color = 2'b00;
    if (bus.sample_valid) begin
      case (state)
        IDLE: begin
          count_next = 4'd0;
          if (sample_class != 2'b00) begin
            cand_next  = sample_class;
            count_next = 4'd1;
            state_next = TRACK;
          end
        end
        TRACK: begin
          if (sample_class == cand) begin
            if (count_inc == CONFIRM) begin
              state_next  = LOCKED;
              stable_next = cand;
              count_next  = 4'd0;
              raise       = 1'b1;
              raise_color = cand;
            end else begin
              count_next = count_inc;
            end
          end else if (sample_class != 2'b00) begin
            cand_next  = sample_class;
            count_next = 4'd1;
          end else begin
            count_next = 4'd0;
            state_next = IDLE;
          end
        end
        LOCKED: begin
          if (sample_class == stable) begin
            count_next = 4'd0;
          end else if (count_inc == CONFIRM) begin
            stable_next = sample_class;
            count_next  = 4'd0;
            raise       = 1'b1;
            raise_color = sample_class;
            if (sample_class == 2'b00) state_next = IDLE;
          end else begin
            count_next = count_inc;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = 4'd0;
        end
      endcase
    end else if (timeout_hit) begin
      state_next = IDLE;
      count_next = 4'd0;
      if (stable != 2'b00) begin
        stable_next = 2'b00;
        raise       = 1'b1;
        raise_color = 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cand   <= 2'b00;
      stable <= 2'b00;
      count  <= 4'd0;
    end else begin
      state  <= state_next;
      cand   <= cand_next;
      stable <= stable_next;
      count  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd      <= 24'd0;
      stale_q <= 1'b0;
    end else if (bus.sample_valid) begin
      wd      <= 24'd0;
      stale_q <= 1'b0;
    end else begin
      if (wd != TIMEOUT_MAX) wd <= wd + 24'd1;
      if (timeout_hit) stale_q <= 1'b1;
    end
  end

  // A new event always wins the slot; it only counts as lost if nothing left this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_color_q <= 2'b00;
      overrun_q   <= 1'b0;
    end else if (raise) begin
      evt_valid_q <= 1'b1;
      evt_color_q <= raise_color;
      if (evt_valid_q && !bus.evt_ready) overrun_q <= 1'b1;
    end else if (evt_valid_q && bus.evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign bus.stable_color = stable;
  assign bus.stable_valid = (stable != 2'b00);
  assign bus.confidence   = count;
  assign bus.stale        = stale_q;
  assign bus.evt_valid    = evt_valid_q;
  assign bus.evt_color    = evt_color_q;
  assign bus.evt_overrun  = overrun_q;

endmodule

`default_nettype wire

// File: doc/color_vote_filter.md
COLOR_VOTE_FILTER -- requirements
Module: color_vote_filter

Interface
REQ-001 The module SHALL have parameter CONFIRM_FRAMES, default 4, meaning the number of agreeing samples needed to change the stable colour (legal range 2..15).
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum number of clocks between samples before the output is declared stale (legal range 1..2^24-1).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_valid  input  1  one-cycle pulse per frame; the detection flags are valid in that cycle.
REQ-006 red_detected  input  1  per-frame red classification.
REQ-007 green_detected  input  1  per-frame green classification.
REQ-008 black_detected  input  1  per-frame black classification.
REQ-009 stable_color  output  2  confirmed colour: 00 none, 01 red, 10 green, 11 black.
REQ-010 stable_valid  output  1  high while stable_color is not none.
REQ-011 confidence  output  4  current agreement or mismatch count (see REQ-017 to REQ-019).
REQ-012 stale  output  1  high while no sample has arrived within TIMEOUT_CYCLES.
REQ-013 evt_valid, evt_color[1:0], evt_ready  output/output/input  change-event handshake toward the consumer.
REQ-014 evt_overrun  output  1  sticky flag: an event was overwritten before it was accepted.

Function
REQ-015 Per-sample class SHALL use priority black > red > green > none; multiple asserted flags resolve by that priority.
REQ-016 The FSM SHALL have states IDLE, TRACK and LOCKED, and SHALL act only in cycles where sample_valid=1, apart from the timeout.
REQ-017 IDLE: a class other than none loads candidate=class, sets count=1 and moves to TRACK; a none class stays in IDLE with count=0.
REQ-018 TRACK: class==candidate increments count; when the increment reaches CONFIRM_FRAMES, go to LOCKED, set stable_color=candidate, count=0 and raise an event. A different class other than none reloads candidate with count=1. A none class returns to IDLE with count=0.
REQ-019 LOCKED: class==stable_color clears the mismatch count. Any other class increments it. When the mismatch count reaches CONFIRM_FRAMES, stable_color takes the current class, count clears and an event is raised; if that class is none, the state becomes IDLE, otherwise it stays LOCKED.
REQ-020 confidence SHALL show the TRACK agreement count in TRACK, the mismatch count in LOCKED, and 0 in IDLE.
REQ-021 Output latency SHALL be 1 clock: stable_color, stable_valid and the evt_valid rise are all registered on the edge after the deciding sample_valid.
REQ-022 A watchdog counter (24 bits) SHALL clear on every sample_valid and saturate at TIMEOUT_CYCLES.
REQ-023 On reaching TIMEOUT_CYCLES, the block SHALL set stale=1 and force IDLE. If stable_color was not none, it SHALL set stable_color=none and raise an event.
REQ-024 stale SHALL clear on the next sample_valid. That sample SHALL be processed normally from IDLE.
REQ-025 Event handshake: evt_valid and evt_color SHALL hold until a cycle with evt_valid and evt_ready both high, after which evt_valid drops on the next edge.
REQ-026 If a new event arises while evt_valid=1 and no transfer occurs that cycle, evt_color SHALL be replaced with the new value, evt_valid SHALL stay high and evt_overrun SHALL set.
REQ-027 If a new event coincides with a transfer, evt_valid SHALL stay high carrying the new colour and evt_overrun SHALL be unchanged.
REQ-028 A timeout coinciding with sample_valid SHALL be ignored; the sample wins and the watchdog clears.

Reset
REQ-029 On a reset=1 clock edge, all outputs SHALL go to 0: stable_color=00, stable_valid=0, confidence=0, stale=0, evt_valid=0, evt_color=00, evt_overrun=0.
REQ-030 On the same edge, the FSM SHALL enter IDLE and the candidate, counts and watchdog SHALL clear.
REQ-031 Reset SHALL take priority over all inputs, including reset asserted mid-TRACK or while an event is pending; a pending event is discarded.

Verification
REQ-032 4 red samples, evt_ready=1 -> stable_color=01 one clock after the 4th sample; evt_valid for 1 cycle with evt_color=01; confidence sequence 1,2,3,0.
REQ-033 red,red,green,green,green,green -> candidate restarts at the first green; stable_color=10 after the 6th sample; no red event.
REQ-034 Locked red, then none,red,none,none,none,none -> the red sample resets the mismatch count; stable_color=00 and state IDLE after the 6th sample.
REQ-035 Red and black flags set together for 4 samples -> stable_color=11.
REQ-036 evt_ready=0 with red then green confirmed -> evt_color=10, evt_overrun=1, evt_valid held high until evt_ready=1.
REQ-037 Locked green, then sample_valid withheld for TIMEOUT_CYCLES (set to 100) -> stale=1, stable_color=00, event 00. The next sample clears stale.
